// File: rtl/xact_pkg.sv
// Shared types for the transaction responder: FSM state and queued request.
// Request fields are sized to the largest supported bus; the top zero-extends.
package xact_pkg;

  localparam int XACT_MAX_DW = 64;
  localparam int XACT_MAX_AW = 8;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } xact_state_e;

  typedef struct packed {
    logic                   write;
    logic [XACT_MAX_AW-1:0] addr;
    logic [XACT_MAX_DW-1:0] wdata;
  } xact_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/xact_req_fifo.sv
// Request FIFO; pointers carry an extra wrap bit so full and empty differ.
// Depth must be a power of two, at least 2.
module xact_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/xact_responder.sv
// Register-file transaction responder: FIFO-queued requests, one response at a time.
// Define XACT_RESPONDER_STATS_EN to add saturating write/read/error counters.
module xact_responder
  import xact_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
`ifdef XACT_RESPONDER_STATS_EN
  ,
  output logic [15:0]           stat_wr_cnt,
  output logic [15:0]           stat_rd_cnt,
  output logic [15:0]           stat_err_cnt
`endif
);

  xact_req_t             w_push_req;
  xact_req_t             w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_idx;

  logic                  r_rdy_en;
  xact_state_e           r_state;
  xact_req_t             r_cur;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

`ifdef XACT_RESPONDER_STATS_EN
  logic [15:0] r_stat_wr;
  logic [15:0] r_stat_rd;
  logic [15:0] r_stat_err;

  assign stat_wr_cnt  = r_stat_wr;
  assign stat_rd_cnt  = r_stat_rd;
  assign stat_err_cnt = r_stat_err;
`endif

  always_comb begin
    w_push_req       = '0;
    w_push_req.write = req_write;
    w_push_req.addr  = XACT_MAX_AW'(req_addr);
    w_push_req.wdata = XACT_MAX_DW'(req_wdata);
  end

  assign req_ready = r_rdy_en && !w_full;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_idx     = r_cur.addr[ADDR_WIDTH-1:0];
  assign w_hit     = 32'(r_cur.addr) < NUM_REGS;

  xact_req_fifo #(
    .WIDTH ($bits(xact_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_push_req),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Holds req_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cur     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
`ifdef XACT_RESPONDER_STATS_EN
      r_stat_wr  <= '0;
      r_stat_rd  <= '0;
      r_stat_err <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_cur   <= w_head;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_state   <= RESP;
          rsp_err   <= !w_hit;
          rsp_rdata <= '0;
          if (w_hit) begin
            if (r_cur.write)
              r_regs[w_idx] <= r_cur.wdata[DATA_WIDTH-1:0];
            else
              rsp_rdata <= r_regs[w_idx];
          end
`ifdef XACT_RESPONDER_STATS_EN
          if (!w_hit)           r_stat_err <= sat_inc16(r_stat_err);
          else if (r_cur.write) r_stat_wr  <= sat_inc16(r_stat_wr);
          else                  r_stat_rd  <= sat_inc16(r_stat_rd);
`endif
        end
        // First RESP cycle raises valid; data was settled in EXEC.
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xact_responder.sv
// Directed bench for xact_responder; stats checks need XACT_RESPONDER_STATS_EN.
module tb_xact_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef XACT_RESPONDER_STATS_EN
  logic [15:0] stat_wr_cnt;
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_err_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xact_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef XACT_RESPONDER_STATS_EN
    ,
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_err_cnt (stat_err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [3:0] a,
                      input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("send_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] rd, output logic er);
    int t = 0;
    rd = '0;
    er = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      rsp_ready = 1'b0;
      return;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic [31:0] erd,
                      input logic eer);
    logic [31:0] rd;
    logic        er;
    send(w, a, d);
    get_rsp(rd, er);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, er, eer);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  logic        q_w   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0]  q_a   [6] = '{4'd0, 4'd1, 4'd0, 4'd14, 4'd1, 4'd2};
  logic [31:0] q_d   [6] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0,
                             32'h0000DEAD, 32'h0, 32'h0};
  logic [31:0] q_erd [5] = '{32'h0, 32'h0, 32'hA0A0A0A0, 32'h0, 32'hB1B1B1B1};
  logic        q_eer [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int          acc;
    int          seen;
    int          t;
    logic [31:0] rd;
    logic        er;

    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", req_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_edge", req_ready, 1);

    // Write then read back
    xact("wr3", 1'b1, 4'd3, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("rd3", 1'b0, 4'd3, 32'h0, 32'hDEADBEEF, 1'b0);

    // Out-of-range accesses and clean register file
    do_reset();
    xact("rd13", 1'b0, 4'd13, 32'h0, 32'h0, 1'b1);
    xact("wr15", 1'b1, 4'd15, 32'hFFFFFFFF, 32'h0, 1'b1);
    for (int i = 0; i < 12; i++)
      xact($sformatf("clr%0d", i), 1'b0, 4'(i), 32'h0, 32'h0, 1'b0);
    xact("wr11", 1'b1, 4'd11, 32'hA5A50011, 32'h0, 1'b0);
    xact("rd11", 1'b0, 4'd11, 32'h0, 32'hA5A50011, 1'b0);
    xact("rd12", 1'b0, 4'd12, 32'h0, 32'h0, 1'b1);

    // Latency and hold under backpressure
    do_reset();
    xact("wr5", 1'b1, 4'd5, 32'h12345678, 32'h0, 1'b0);
    send(1'b0, 4'd5, 32'h0);
    @(posedge clk);
    #1 chk("lat_e1", rsp_valid, 0);
    @(posedge clk);
    #1 chk("lat_e2", rsp_valid, 0);
    @(posedge clk);
    #1 chk("lat_e3", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, 32'h12345678);
      chk("hold_err", rsp_err, 0);
    end
    get_rsp(rd, er);
    chk("lat_rdata", rd, 32'h12345678);

    // Fill FIFO with consumer stalled
    do_reset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = q_w[i];
      req_addr  = q_a[i];
      req_wdata = q_d[i];
      if (req_ready) acc++;
    end
    repeat (3) @(negedge clk);
    chk("full_ready", req_ready, 0);
    req_valid = 1'b0;
    chk("full_accepted", acc, 5);
    for (int i = 0; i < 5; i++) begin
      get_rsp(rd, er);
      chk($sformatf("order%0d_rdata", i), rd, q_erd[i]);
      chk($sformatf("order%0d_err", i), er, q_eer[i]);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("full_no_extra", seen, 0);
    chk("full_ready_again", req_ready, 1);

    // Reset while a response is pending
    do_reset();
    send(1'b1, 4'd2, 32'h22);
    send(1'b1, 4'd4, 32'h44);
    send(1'b1, 4'd6, 32'h66);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("pre_rst_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1 chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    chk("stale_rsp", seen, 0);
    xact("post_rd2", 1'b0, 4'd2, 32'h0, 32'h0, 1'b0);
    xact("post_rd4", 1'b0, 4'd4, 32'h0, 32'h0, 1'b0);
    xact("post_rd6", 1'b0, 4'd6, 32'h0, 32'h0, 1'b0);

`ifdef XACT_RESPONDER_STATS_EN
    do_reset();
    chk("stat_rst_wr", stat_wr_cnt, 0);
    xact("s_w0", 1'b1, 4'd0, 32'h1, 32'h0, 1'b0);
    xact("s_w1", 1'b1, 4'd1, 32'h2, 32'h0, 1'b0);
    xact("s_r0", 1'b0, 4'd0, 32'h0, 32'h1, 1'b0);
    xact("s_w2", 1'b1, 4'd2, 32'h3, 32'h0, 1'b0);
    xact("s_bad", 1'b1, 4'd14, 32'h4, 32'h0, 1'b1);
    xact("s_r1", 1'b0, 4'd1, 32'h0, 32'h2, 1'b0);
    chk("stat_wr", stat_wr_cnt, 3);
    chk("stat_rd", stat_rd_cnt, 2);
    chk("stat_err", stat_err_cnt, 1);
    @(negedge clk);
    force dut.r_stat_wr = 16'hFFFF;
    @(negedge clk);
    release dut.r_stat_wr;
    xact("s_w3", 1'b1, 4'd3, 32'h5, 32'h0, 1'b0);
    xact("s_w4", 1'b1, 4'd4, 32'h6, 32'h0, 1'b0);
    chk("stat_wr_sat", stat_wr_cnt, 16'hFFFF);
    chk("stat_rd_hold", stat_rd_cnt, 2);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xact_responder.md
XACT_RESPONDER -- requirements
Module: xact_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register and data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, request address width.
REQ-003 SHALL have parameter NUM_REGS, default 12, implemented registers (<= 2**ADDR_WIDTH).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, request FIFO entries (power of two, >= 2).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request FIFO can accept.
REQ-009 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  ADDR_WIDTH  register index.
REQ-011 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-014 SHALL have port rsp_rdata  output  DATA_WIDTH  read data (0 for writes and errors).
REQ-015 SHALL have port rsp_err  output  1  address out of range.

Function
REQ-016 Request SHALL be accepted on a rising edge where req_valid && req_ready; req_ready = !fifo_full, with no same-cycle pop bypass.
REQ-017 FSM SHALL have states IDLE, EXEC, RESP.
REQ-018 IDLE: if FIFO non-empty, pop head and go EXEC; else stay.
REQ-019 EXEC (one cycle): write updates register if addr < NUM_REGS; read captures register; addr >= NUM_REGS sets err, write discarded, rdata 0; go RESP.
REQ-020 RESP: rsp_valid = 1 with rsp_rdata/rsp_err stable until rsp_valid && rsp_ready, then go IDLE.
REQ-021 With the FIFO empty and the FSM in IDLE, rsp_valid SHALL rise in the cycle after the third rising edge following the acceptance edge (3-cycle latency).
REQ-022 Responses SHALL be returned in request order, one outstanding response at a time.
REQ-023 Read after write to the same address SHALL return the written value.
REQ-024 Acceptance SHALL continue while the FSM is in EXEC or RESP until the FIFO is full.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, FIFO empty, all registers 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0 while in reset.
REQ-027 req_ready SHALL go 1 on the first rising edge after rst_n deasserts.
REQ-028 Reset mid-transaction SHALL drop pending and in-flight requests with no response.

Configuration
REQ-029 Macro XACT_RESPONDER_STATS_EN SHALL add outputs stat_wr_cnt, stat_rd_cnt and stat_err_cnt (each 16 bits, reset 0, saturating at 16'hFFFF), incremented on the EXEC cycle by operation type.
REQ-030 Without XACT_RESPONDER_STATS_EN, the stat ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package xact_pkg SHALL hold the state enum and the packed request struct (write, addr, wdata).
REQ-032 The FIFO SHALL be sub-module xact_req_fifo (parameterised width/depth; push, pop, full, empty).

Verification
REQ-033 Write addr 3 data 0xDEADBEEF, then read addr 3 -> write rsp (rdata 0, err 0), then read rsp rdata 0xDEADBEEF, err 0.
REQ-034 Read addr 13 and write addr 15 -> rsp_err 1, rdata 0; a subsequent read of every register returns 0.
REQ-035 rsp_ready held 0 and 6 requests offered -> 4 accepted into the FIFO plus 1 popped in flight; req_ready 0 thereafter; releasing rsp_ready returns all accepted responses in order.
REQ-036 Single read to an idle block -> rsp_valid high in the cycle after the third edge following acceptance; rsp_ready 0 for 5 cycles -> outputs stable throughout.
REQ-037 rst_n asserted while in RESP with 2 requests queued -> rsp_valid 0 immediately, no stale responses after release, registers read 0.
REQ-038 With XACT_RESPONDER_STATS_EN: 3 writes, 2 reads, 1 bad address -> stat_wr_cnt 3, stat_rd_cnt 2, stat_err_cnt 1; forced 16'hFFFF holds on further writes.
